// File: rtl/vga_draw_arbiter.sv
// Round-robin arbiter granting one of three drawing clients ownership of the
// VGA plot port per burst, with registered pixel path, on-screen range check,
// a mandatory one-cycle gap between bursts and an idle watchdog.
module vga_draw_arbiter #(
  parameter logic [7:0] X_SCREEN_PIXELS = 8'd160,
  parameter logic [6:0] Y_SCREEN_PIXELS = 7'd120,
  parameter logic [7:0] TIMEOUT         = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [2:0] pix_valid,
  input  logic [2:0] pix_last,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [7:0] x2,
  input  logic [6:0] y0,
  input  logic [6:0] y1,
  input  logic [6:0] y2,
  input  logic [2:0] c0,
  input  logic [2:0] c1,
  input  logic [2:0] c2,
  output logic [2:0] gnt,
  output logic [7:0] xout,
  output logic [6:0] yout,
  output logic [2:0] colourOut,
  output logic       drawEn,
  output logic       busy,
  output logic       timeout_err,
  output logic       drop_err
);

  localparam int unsigned XW  = 8;
  localparam int unsigned YW  = 7;
  localparam int unsigned CW  = 3;
  localparam int unsigned NC  = 3;
  localparam int unsigned WDW = 8;

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_e;

  state_e         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     owner_q, owner_d;
  logic [NC-1:0]  gnt_q, gnt_d;
  logic           busy_q, busy_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [XW-1:0]  xout_q, xout_d;
  logic [YW-1:0]  yout_q, yout_d;
  logic [CW-1:0]  col_q, col_d;
  logic           draw_q, draw_d;
  logic           drop_q, drop_d;
  logic           tmo_q, tmo_d;

  logic           sel_pv, sel_last;
  logic [XW-1:0]  sel_x;
  logic [YW-1:0]  sel_y;
  logic [CW-1:0]  sel_c;
  logic           win_found;
  logic [1:0]     win_idx;
  logic [2:0]     cand;
  logic [1:0]     next_ptr;
  logic           in_range;

  // Route the current owner's pixel interface; other clients are ignored.
  always_comb begin
    sel_pv   = 1'b0;
    sel_last = 1'b0;
    sel_x    = '0;
    sel_y    = '0;
    sel_c    = '0;
    case (owner_q)
      2'd0: begin sel_pv = pix_valid[0]; sel_last = pix_last[0]; sel_x = x0; sel_y = y0; sel_c = c0; end
      2'd1: begin sel_pv = pix_valid[1]; sel_last = pix_last[1]; sel_x = x1; sel_y = y1; sel_c = c1; end
      2'd2: begin sel_pv = pix_valid[2]; sel_last = pix_last[2]; sel_x = x2; sel_y = y2; sel_c = c2; end
      default: ;
    endcase
  end

  // Round-robin search over requesters starting at the pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 3'd0;
    for (int unsigned k = 0; k < NC; k++) begin
      cand = 3'(ptr_q) + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!win_found && req[cand[1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end

  assign next_ptr = (owner_q == 2'd2) ? 2'd0 : 2'(owner_q + 2'd1);
  assign in_range = (sel_x < X_SCREEN_PIXELS) && (sel_y < Y_SCREEN_PIXELS);

  // Next-state, grant, watchdog and pixel-path logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    wd_d    = wd_q;
    xout_d  = xout_q;
    yout_d  = yout_q;
    col_d   = col_q;
    draw_d  = 1'b0;
    drop_d  = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (win_found) begin
          state_d = S_OWN;
          owner_d = win_idx;
          gnt_d   = 3'b001 << win_idx;
          busy_d  = 1'b1;
          wd_d    = '0;
        end
      end
      S_OWN: begin
        if (sel_pv) begin
          wd_d = '0;
          if (in_range) begin
            xout_d = sel_x;
            yout_d = sel_y;
            col_d  = sel_c;
            draw_d = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
          if (sel_last) begin
            state_d = S_GAP;
            gnt_d   = '0;
            busy_d  = 1'b0;
            ptr_d   = next_ptr;
          end
        end else if (WDW'(wd_q + 8'd1) == TIMEOUT) begin
          tmo_d   = 1'b1;
          wd_d    = '0;
          state_d = S_GAP;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = next_ptr;
        end else begin
          wd_d = WDW'(wd_q + 8'd1);
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      wd_q    <= '0;
      xout_q  <= '0;
      yout_q  <= '0;
      col_q   <= '0;
      draw_q  <= 1'b0;
      drop_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      wd_q    <= wd_d;
      xout_q  <= xout_d;
      yout_q  <= yout_d;
      col_q   <= col_d;
      draw_q  <= draw_d;
      drop_q  <= drop_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt         = gnt_q;
  assign busy        = busy_q;
  assign xout        = xout_q;
  assign yout        = yout_q;
  assign colourOut   = col_q;
  assign drawEn      = draw_q;
  assign drop_err    = drop_q;
  assign timeout_err = tmo_q;

endmodule
